spi_rx_controller: RTL and testbench
====================================

Name: spi_rx_controller

Overview:
- SPI-slave receive front end; sits directly upstream of the ShiftRegister block.
- Synchronises raw SPI pins (SCK, MOSI, CSn) into the system clock domain and detects SCK sampling edges.
- Drives the shift register's serial input and enable, one pulse per bit, and captures its parallel output after each complete word.
- Presents each captured word downstream on a single-entry valid/ready buffer, with overrun detection.

Parameters:
DATA_WIDTH, 8, word length in bits; must equal the attached shift register width
SYNC_STAGES, 2, flip-flop stages per synchroniser (minimum 2)
SAMPLE_RISING, 1, 1 = sample MOSI on SCK rising edge (SPI mode 0); 0 = falling edge (mode 1)

Ports:
clock  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-low reset
io_sck  in  1  raw SPI clock, asynchronous to clock
io_mosi  in  1  raw SPI data in
io_csn  in  1  raw SPI chip select, active low
io_shiftIn  out  1  serial bit to the shift register's io_in
io_shiftEnable  out  1  one-cycle shift strobe to the shift register's io_enable
io_shiftData  in  DATA_WIDTH  parallel word from the shift register's io_out
io_outData  out  DATA_WIDTH  buffered received word
io_outValid  out  1  buffer holds a word
io_outReady  in  1  consumer accepts the word when valid && ready
io_overrun  out  1  sticky: a completed word was dropped
io_busy  out  1  high while in SHIFT or CAPTURE

Behaviour:
- Reset (reset==0 at a clock edge): all outputs 0; FSM in IDLE; bit counter 0; synchronisers loaded with idle levels (sck=0, mosi=0, csn=1).
- Synchronisers: SYNC_STAGES flops on each of sck, mosi and csn. One extra register on synchronised sck feeds edge detection.
- Sample edge: synchronised sck transitions 0->1 (SAMPLE_RISING=1) or 1->0 (SAMPLE_RISING=0).
- FSM states: IDLE, SHIFT, CAPTURE.
  - IDLE -> SHIFT when synchronised csn==0. On entry: bit counter cleared; io_overrun cleared.
  - SHIFT, on a sample edge: io_shiftEnable=1 for exactly one cycle; io_shiftIn = synchronised mosi in that same cycle; counter increments.
  - SHIFT -> CAPTURE: in the cycle the pulse for bit DATA_WIDTH-1 issues, the counter wraps to 0.
  - SHIFT -> IDLE: if synchronised csn==1 before the word completes. Partial word discarded; no capture; counter cleared.
  - CAPTURE lasts one cycle and samples io_shiftData, which is valid the cycle after the last enable.
  - CAPTURE -> SHIFT if csn still low; otherwise -> IDLE.
- Latency:
  - Pin SCK edge to io_shiftEnable: SYNC_STAGES+1 clocks.
  - Last io_shiftEnable to io_outValid high: 2 clocks.
- Output buffer (single entry):
  - Loaded in CAPTURE if empty, or if being accepted in the same cycle (valid && ready): new word loaded, valid stays 1, no overrun.
  - Full and not accepted at CAPTURE: new word dropped, old word kept, io_overrun set.
  - io_outValid falls the cycle after acceptance unless reloaded.
- Timing constraint on the SPI master: SCK high and low times each >= SYNC_STAGES+2 clock cycles. Faster SCK is unsupported and edges may be missed.
- io_shiftIn holds its last value when io_shiftEnable==0.
- Reset mid-word: aborts the word; buffer emptied.

Decomposition:
- Shared package spi_pkg: FSM state encoding (IDLE/SHIFT/CAPTURE), DATA_WIDTH default, counter width = clog2(DATA_WIDTH).
- One sub-module: spi_sync_edge. Parameterised synchroniser plus edge detector; outputs synchronised level, rise pulse and fall pulse. Instantiated for sck and csn; mosi needs the level only.
- The ShiftRegister itself is instantiated by the bench or the parent, not inside this block.

Test Plan:
- Reset: hold reset=0 for 3 clocks with pins toggling -> all outputs 0, no io_shiftEnable pulses.
- Single byte 0xA5, mode 0, SCK half-period 100 ns, clock 20 ns, CSn low -> exactly 8 io_shiftEnable pulses with io_shiftIn = 1,0,1,0,0,1,0,1; io_outData=0xA5 with io_outValid high 2 clocks after the 8th pulse; accepted with io_outReady=1 -> valid drops the next cycle.
- Back-to-back 0x3C then 0xC3 with io_outReady tied high -> two valid pulses, data 0x3C then 0xC3, io_overrun=0.
- Overrun: io_outReady=0, send 0x11 then 0x22 -> io_outData stays 0x11, io_overrun=1 after the second capture; a new CSn falling edge clears io_overrun.
- Abort: CSn rises after 5 bits -> FSM returns to IDLE, no io_outValid. A following full byte 0x7E is then received correctly.
- Mode 1 (SAMPLE_RISING=0), byte 0x81 -> pulses aligned to synchronised SCK falling edges, io_outData=0x81.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//
// Shared definitions for the SPI-slave receive front end:
//   - rx_state_t      : receive FSM state encoding (IDLE / SHIFT / CAPTURE)
//   - DATA_WIDTH_DEF  : default word length in bits
//   - SYNC_STAGES_MIN : shallowest synchroniser that still resolves metastability
//   - cnt_width()     : bit-counter width for a given word length
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // waiting for chip select
        ST_SHIFT   = 2'd1,  // issuing one shift strobe per sampled SCK edge
        ST_CAPTURE = 2'd2   // one cycle: latch the shift register's parallel word
    } rx_state_t;

    // Counter width able to index bits 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
//
// Multi-flop synchroniser for one asynchronous pin, followed by a single
// history register that turns level changes into one-cycle edge pulses.
//
// Parameters:
//   SYNC_STAGES  flops in the synchroniser chain (2 or more)
//   RESET_LEVEL  value loaded into the whole chain at reset, i.e. the pin's
//                idle level, so no false edge is seen when reset releases
//
// Ports:
//   clock     in   system clock
//   reset     in   synchronous, active-low reset
//   async_in  in   raw pin, asynchronous to clock
//   level     out  synchronised level
//   rise      out  one-cycle pulse: level went 0 -> 1
//   fall      out  one-cycle pulse: level went 1 -> 0
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values from before the edge; blocking here would collapse
    // the synchroniser chain into a single stage.
    // NOTE: the chain is small and must not wake up holding X or a non-idle
    // value, so every stage is reset; wide storage arrays would not be.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            prev_q <= RESET_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  =  level & ~prev_q;
    assign fall  = ~level &  prev_q;

endmodule : spi_sync_edge

// File: rtl/spi_rx_controller.sv
// -----------------------------------------------------------------------------
// spi_rx_controller
//
// SPI-slave receive front end sitting directly upstream of an external shift
// register. Raw SCK / MOSI / CSn are synchronised into the clock domain; each
// sampled SCK edge produces one shift strobe carrying the sampled MOSI bit.
// After DATA_WIDTH strobes the shift register's parallel output is captured
// into a single-entry valid/ready buffer. A word completing while the buffer
// is full and not being drained is dropped and flagged as a sticky overrun.
//
// Parameters:
//   DATA_WIDTH     word length; must match the attached shift register
//   SYNC_STAGES    synchroniser depth per pin (2 or more)
//   SAMPLE_RISING  1: sample MOSI on SCK rising edge (mode 0)
//                  0: sample MOSI on SCK falling edge (mode 1)
//
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   synchronous, active-low reset
//   io_sck          in   raw SPI clock
//   io_mosi         in   raw SPI data
//   io_csn          in   raw SPI chip select, active low
//   io_shiftIn      out  serial bit to the shift register (held between strobes)
//   io_shiftEnable  out  one-cycle shift strobe
//   io_shiftData    in   shift register parallel output
//   io_outData      out  buffered word
//   io_outValid     out  buffer holds a word
//   io_outReady     in   consumer takes the word when valid && ready
//   io_overrun      out  sticky: a completed word was dropped this frame
//   io_busy         out  FSM is in SHIFT or CAPTURE
//
// Timing: pin SCK edge to io_shiftEnable is SYNC_STAGES+1 clocks; the last
// strobe to io_outValid is 2 clocks (strobe -> shift register updates ->
// CAPTURE samples it). SCK high and low times must each be at least
// SYNC_STAGES+2 clocks or edges may be missed.
// -----------------------------------------------------------------------------
module spi_rx_controller
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter bit SAMPLE_RISING = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_sck,
    input  logic                  io_mosi,
    input  logic                  io_csn,
    output logic                  io_shiftIn,
    output logic                  io_shiftEnable,
    input  logic [DATA_WIDTH-1:0] io_shiftData,
    output logic [DATA_WIDTH-1:0] io_outData,
    output logic                  io_outValid,
    input  logic                  io_outReady,
    output logic                  io_overrun,
    output logic                  io_busy
);

    localparam int               CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------
    // Pin synchronisation
    // ------------------------------------------------------------------
    logic sck_level_unused;
    logic sck_rise;
    logic sck_fall;
    logic csn_level;
    // The FSM works from the chip-select level; its transitions are not needed.
    logic csn_rise_unused;
    logic csn_fall_unused;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (1'b0)
    ) u_sck_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (io_sck),
        .level    (sck_level_unused),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (1'b1)
    ) u_csn_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (io_csn),
        .level    (csn_level),
        .rise     (csn_rise_unused),
        .fall     (csn_fall_unused)
    );

    // MOSI only needs its level. Same depth as SCK, so the bit seen alongside a
    // detected SCK edge is the bit that was on the pin at that SCK edge.
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_level;

    always_ff @(posedge clock) begin
        if (!reset) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], io_mosi};
        end
    end

    assign mosi_level = mosi_sync_q[SYNC_STAGES-1];

    logic sample_edge;
    assign sample_edge = SAMPLE_RISING ? sck_rise : sck_fall;

    // ------------------------------------------------------------------
    // Receive FSM and output buffer
    // ------------------------------------------------------------------
    rx_state_t              state_q,     state_d;
    logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
    logic                   shift_en_q,  shift_en_d;
    logic                   shift_in_q,  shift_in_d;
    logic [DATA_WIDTH-1:0]  out_data_q,  out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q,   overrun_d;
    logic                   accept;

    assign accept = out_valid_q && io_outReady;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_en_q  <= 1'b0;
            shift_in_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_en_q  <= shift_en_d;
            shift_in_q  <= shift_in_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_en_d  = 1'b0;
        shift_in_d  = shift_in_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        // A word taken by the consumer empties the buffer unless CAPTURE
        // reloads it below in the same cycle.
        if (accept) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!csn_level) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    overrun_d = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (csn_level) begin
                    // Frame ended mid-word: the partial word is abandoned.
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else begin
                    if (sample_edge) begin
                        shift_en_d = 1'b1;
                        shift_in_d = mosi_level;
                    end
                    // Bits are counted while their strobe is on the output, so
                    // the strobe for the last bit moves the FSM to CAPTURE just
                    // as the shift register absorbs that bit.
                    if (shift_en_q) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            state_d   = ST_CAPTURE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end

            ST_CAPTURE: begin
                if (!out_valid_q || accept) begin
                    out_data_d  = io_shiftData;
                    out_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = csn_level ? ST_IDLE : ST_SHIFT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign io_shiftIn     = shift_in_q;
    assign io_shiftEnable = shift_en_q;
    assign io_outData     = out_data_q;
    assign io_outValid    = out_valid_q;
    assign io_overrun     = overrun_q;
    assign io_busy        = (state_q == ST_SHIFT) || (state_q == ST_CAPTURE);

endmodule : spi_rx_controller

// File: tb/tb_spi_rx_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_controller
//
// Two receivers share the SPI pins: dut0 samples on SCK rising edges (mode 0),
// dut1 on falling edges (mode 1). Each drives its own behavioural shift
// register. A negedge monitor logs strobes, valid rises and accepted words;
// the scenario tasks compare those logs with values derived from the bytes
// they sent and from the word-level buffer rules.
// -----------------------------------------------------------------------------
module tb_spi_rx_controller;

    localparam int DW = 8;
    localparam int SS = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sck   = 1'b0;
    logic mosi  = 1'b0;
    logic csn   = 1'b1;

    logic          shift_in0, shift_en0, out_valid0, overrun0, busy0;
    logic          shift_in1, shift_en1, out_valid1, overrun1, busy1;
    logic [DW-1:0] out_data0, out_data1;
    logic [DW-1:0] sr0, sr1;
    logic          out_ready0 = 1'b0;
    logic          out_ready1 = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #10 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    spi_rx_controller #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .SAMPLE_RISING(1'b1)) dut0 (
        .clock(clock), .reset(reset), .io_sck(sck), .io_mosi(mosi), .io_csn(csn),
        .io_shiftIn(shift_in0), .io_shiftEnable(shift_en0), .io_shiftData(sr0),
        .io_outData(out_data0), .io_outValid(out_valid0), .io_outReady(out_ready0),
        .io_overrun(overrun0), .io_busy(busy0)
    );

    spi_rx_controller #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .SAMPLE_RISING(1'b0)) dut1 (
        .clock(clock), .reset(reset), .io_sck(sck), .io_mosi(mosi), .io_csn(csn),
        .io_shiftIn(shift_in1), .io_shiftEnable(shift_en1), .io_shiftData(sr1),
        .io_outData(out_data1), .io_outValid(out_valid1), .io_outReady(out_ready1),
        .io_overrun(overrun1), .io_busy(busy1)
    );

    // External MSB-first shift registers.
    always @(posedge clock) begin
        if (!reset)         sr0 <= '0;
        else if (shift_en0) sr0 <= {sr0[DW-2:0], shift_in0};
        if (!reset)         sr1 <= '0;
        else if (shift_en1) sr1 <= {sr1[DW-2:0], shift_in1};
    end

    // Monitor logs.
    logic          bits0_q[$], bits1_q[$];
    int            pcyc0_q[$], pcyc1_q[$];
    int            vrise0_q[$], vrise1_q[$];
    logic [DW-1:0] acc0_q[$], acc1_q[$];
    logic          valid0_prev = 1'b0;
    logic          valid1_prev = 1'b0;

    always @(negedge clock) begin
        if (shift_en0) begin bits0_q.push_back(shift_in0); pcyc0_q.push_back(cyc); end
        if (shift_en1) begin bits1_q.push_back(shift_in1); pcyc1_q.push_back(cyc); end
        if (out_valid0 && !valid0_prev) vrise0_q.push_back(cyc);
        if (out_valid1 && !valid1_prev) vrise1_q.push_back(cyc);
        if (reset && out_valid0 && out_ready0) acc0_q.push_back(out_data0);
        if (reset && out_valid1 && out_ready1) acc1_q.push_back(out_data1);
        valid0_prev <= out_valid0;
        valid1_prev <= out_valid1;
    end

    // Number of logged strobe bits (from index start) differing from b, MSB first.
    function automatic int bit_errors(input bit which, input int start,
                                      input logic [7:0] b, input int nbits);
        int   errs;
        logic got;
        errs = 0;
        for (int i = 0; i < nbits; i++) begin
            if (which) got = (start + i < bits1_q.size()) ? bits1_q[start + i] : 1'bx;
            else       got = (start + i < bits0_q.size()) ? bits0_q[start + i] : 1'bx;
            if (got !== b[7 - i]) errs++;
        end
        return errs;
    endfunction

    // Pins always change 3 ns after a rising clock edge; 100 ns = 5 clocks.
    task automatic align();
        @(posedge clock);
        #3;
    endtask

    // SPI master, MSB first, SCK half-period 100 ns. Returns the cycle of the
    // first sampling edge on the pin.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit mode0,
                             output int edge_cyc);
        edge_cyc = -1;
        for (int i = 0; i < nbits; i++) begin
            if (mode0) begin
                mosi = b[7 - i]; #100;
                sck = 1'b1; if (i == 0) edge_cyc = cyc; #100;
                sck = 1'b0;
            end else begin
                sck = 1'b1; mosi = b[7 - i]; #100;
                sck = 1'b0; if (i == 0) edge_cyc = cyc; #100;
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            align();
            sck = ~sck; mosi = 1'($urandom_range(0, 1)); csn = 1'b0;
            @(negedge clock);
            n_tests++;
            if ({shift_in0, shift_en0, out_data0, out_valid0, overrun0, busy0} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs_dut0: got %b, expected all zero",
                         {shift_in0, shift_en0, out_data0, out_valid0, overrun0, busy0});
            end
            n_tests++;
            if ({shift_in1, shift_en1, out_data1, out_valid1, overrun1, busy1} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs_dut1: got %b, expected all zero",
                         {shift_in1, shift_en1, out_data1, out_valid1, overrun1, busy1});
            end
        end
        align();
        sck = 1'b0; mosi = 1'b0; csn = 1'b1;
        align(); align();
        reset = 1'b1;
        repeat (5) align();
        @(negedge clock);
        n_tests++;
        if (bits0_q.size() + bits1_q.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_no_strobes: got %0d strobes, expected 0",
                     bits0_q.size() + bits1_q.size());
        end
        n_tests++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b, expected 0", busy0);
        end
    endtask

    task automatic test_single_byte();
        int b0, r0, e, lat, vlat;
        align();
        out_ready0 = 1'b0;
        b0 = bits0_q.size(); r0 = vrise0_q.size();
        csn = 1'b0; #100;
        send_bits(8'hA5, 8, 1'b1, e);
        #100;
        @(negedge clock);
        lat  = (pcyc0_q.size() > b0) ? pcyc0_q[b0] - e : -1;
        vlat = (pcyc0_q.size() >= b0 + 8 && vrise0_q.size() > r0) ? vrise0_q[r0] - pcyc0_q[b0 + 7] : -1;
        n_tests++;
        if (bits0_q.size() - b0 !== 8) begin
            n_fail++; $display("FAIL a5_pulse_count: got %0d, expected 8", bits0_q.size() - b0);
        end
        n_tests++;
        if (bit_errors(1'b0, b0, 8'hA5, 8) !== 0) begin
            n_fail++; $display("FAIL a5_bits: got %0d wrong bits, expected 0", bit_errors(1'b0, b0, 8'hA5, 8));
        end
        n_tests++;
        if (lat !== SS + 1) begin
            n_fail++; $display("FAIL a5_edge_latency: got %0d, expected %0d", lat, SS + 1);
        end
        n_tests++;
        if (vlat !== 2) begin
            n_fail++; $display("FAIL a5_valid_latency: got %0d, expected 2", vlat);
        end
        n_tests++;
        if ({out_valid0, out_data0, overrun0, busy0} !== {1'b1, 8'hA5, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL a5_buffer: got valid=%b data=%h ovr=%b busy=%b, expected 1 a5 0 1",
                     out_valid0, out_data0, overrun0, busy0);
        end
        align();
        csn = 1'b1; #200;
        out_ready0 = 1'b1;
        @(negedge clock);
        n_tests++;
        if (out_valid0 !== 1'b1) begin
            n_fail++; $display("FAIL a5_valid_before_accept: got %b, expected 1", out_valid0);
        end
        align();
        out_ready0 = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({out_valid0, busy0} !== 2'b00) begin
            n_fail++; $display("FAIL a5_valid_after_accept: got valid=%b busy=%b, expected 0 0", out_valid0, busy0);
        end
    endtask

    task automatic test_back_to_back();
        int a0, r0, e;
        align();
        out_ready0 = 1'b1;
        a0 = acc0_q.size(); r0 = vrise0_q.size();
        csn = 1'b0; #100;
        send_bits(8'h3C, 8, 1'b1, e);
        send_bits(8'hC3, 8, 1'b1, e);
        #100;
        csn = 1'b1; #200;
        @(negedge clock);
        n_tests++;
        if (acc0_q.size() - a0 !== 2 || vrise0_q.size() - r0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words %0d valid pulses, expected 2 and 2",
                     acc0_q.size() - a0, vrise0_q.size() - r0);
        end else begin
            n_tests++;
            if ({acc0_q[a0], acc0_q[a0 + 1]} !== 16'h3CC3) begin
                n_fail++; $display("FAIL b2b_data: got %h %h, expected 3c c3", acc0_q[a0], acc0_q[a0 + 1]);
            end
        end
        n_tests++;
        if ({overrun0, out_valid0} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_overrun: got ovr=%b valid=%b, expected 0 0", overrun0, out_valid0);
        end
        align();
        out_ready0 = 1'b0;
    endtask

    task automatic test_overrun();
        int a0, e;
        align();
        out_ready0 = 1'b0;
        csn = 1'b0; #100;
        send_bits(8'h11, 8, 1'b1, e);
        #100;
        @(negedge clock);
        n_tests++;
        if ({out_valid0, out_data0, overrun0} !== {1'b1, 8'h11, 1'b0}) begin
            n_fail++; $display("FAIL ovr_first: got valid=%b data=%h ovr=%b, expected 1 11 0", out_valid0, out_data0, overrun0);
        end
        align();
        send_bits(8'h22, 8, 1'b1, e);
        #100;
        @(negedge clock);
        n_tests++;
        if ({out_valid0, out_data0, overrun0} !== {1'b1, 8'h11, 1'b1}) begin
            n_fail++; $display("FAIL ovr_second: got valid=%b data=%h ovr=%b, expected 1 11 1", out_valid0, out_data0, overrun0);
        end
        align();
        csn = 1'b1; #200;
        @(negedge clock);
        n_tests++;
        if (overrun0 !== 1'b1) begin
            n_fail++; $display("FAIL ovr_sticky: got %b, expected 1", overrun0);
        end
        align();
        csn = 1'b0; #100;
        @(negedge clock);
        n_tests++;
        if ({overrun0, out_valid0, out_data0} !== {1'b0, 1'b1, 8'h11}) begin
            n_fail++; $display("FAIL ovr_cleared: got ovr=%b valid=%b data=%h, expected 0 1 11", overrun0, out_valid0, out_data0);
        end
        align();
        csn = 1'b1; #200;
        a0 = acc0_q.size();
        out_ready0 = 1'b1;
        align();
        out_ready0 = 1'b0;
        @(negedge clock);
        n_tests++;
        if (acc0_q.size() - a0 !== 1 || out_valid0 !== 1'b0) begin
            n_fail++; $display("FAIL ovr_drain: got %0d words valid=%b, expected 1 word valid=0", acc0_q.size() - a0, out_valid0);
        end else begin
            n_tests++;
            if (acc0_q[a0] !== 8'h11) begin
                n_fail++; $display("FAIL ovr_drain_data: got %h, expected 11", acc0_q[a0]);
            end
        end
    endtask

    task automatic test_abort();
        int b0, r0, a0, e;
        logic [7:0] partial;
        partial = 8'($urandom);
        align();
        out_ready0 = 1'b1;
        b0 = bits0_q.size(); r0 = vrise0_q.size();
        csn = 1'b0; #100;
        send_bits(partial, 5, 1'b1, e);
        #100;
        csn = 1'b1; #200;
        @(negedge clock);
        n_tests++;
        if (bits0_q.size() - b0 !== 5 || bit_errors(1'b0, b0, partial, 5) !== 0) begin
            n_fail++; $display("FAIL abort_bits: got %0d strobes, expected 5 matching %h", bits0_q.size() - b0, partial);
        end
        n_tests++;
        if ({vrise0_q.size() - r0, busy0, out_valid0} !== {32'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_idle: got %0d valids busy=%b valid=%b, expected 0 0 0",
                     vrise0_q.size() - r0, busy0, out_valid0);
        end
        align();
        a0 = acc0_q.size();
        csn = 1'b0; #100;
        send_bits(8'h7E, 8, 1'b1, e);
        #100;
        csn = 1'b1; #200;
        @(negedge clock);
        n_tests++;
        if (acc0_q.size() - a0 !== 1) begin
            n_fail++; $display("FAIL abort_recover_count: got %0d, expected 1", acc0_q.size() - a0);
        end else begin
            n_tests++;
            if (acc0_q[a0] !== 8'h7E) begin
                n_fail++; $display("FAIL abort_recover_data: got %h, expected 7e", acc0_q[a0]);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        int e;
        align();
        out_ready0 = 1'b0;
        csn = 1'b0; #100;
        send_bits(8'($urandom), 8, 1'b1, e);
        send_bits(8'($urandom), 4, 1'b1, e);
        reset = 1'b0;
        csn = 1'b1; sck = 1'b0; mosi = 1'b0;
        align(); align();
        @(negedge clock);
        n_tests++;
        if ({out_valid0, out_data0, overrun0, busy0, shift_en0} !== '0) begin
            n_fail++;
            $display("FAIL midword_reset: got valid=%b data=%h ovr=%b busy=%b en=%b, expected all 0",
                     out_valid0, out_data0, overrun0, busy0, shift_en0);
        end
        align();
        reset = 1'b1;
        repeat (5) align();
    endtask

    task automatic test_random_stream();
        logic [7:0] sent[$];
        int a0, e, n;
        n = 6;
        align();
        out_ready0 = 1'b1;
        a0 = acc0_q.size();
        csn = 1'b0; #100;
        for (int i = 0; i < n; i++) begin
            sent.push_back(8'($urandom));
            send_bits(sent[i], 8, 1'b1, e);
        end
        #100;
        csn = 1'b1; #200;
        @(negedge clock);
        n_tests++;
        if (acc0_q.size() - a0 !== n) begin
            n_fail++; $display("FAIL stream_count: got %0d, expected %0d", acc0_q.size() - a0, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_tests++;
                if (acc0_q[a0 + i] !== sent[i]) begin
                    n_fail++; $display("FAIL stream_word%0d: got %h, expected %h", i, acc0_q[a0 + i], sent[i]);
                end
            end
        end
        align();
        out_ready0 = 1'b0;
    endtask

    // Word-level model of the buffer with no consumer: the first completed
    // word fills it, every later word in the frame is lost and flags overrun.
    task automatic test_random_overrun();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] w;
            logic [7:0] exp_data;
            logic       exp_valid, exp_ovr;
            int         n, a0, e;
            n = $urandom_range(1, 3);
            exp_valid = 1'b0; exp_ovr = 1'b0; exp_data = '0;
            align();
            out_ready0 = 1'b0;
            csn = 1'b0; #100;
            for (int i = 0; i < n; i++) begin
                w = 8'($urandom);
                send_bits(w, 8, 1'b1, e);
                if (!exp_valid) begin exp_valid = 1'b1; exp_data = w; end
                else            exp_ovr = 1'b1;
            end
            #100;
            csn = 1'b1; #200;
            @(negedge clock);
            n_tests++;
            if ({out_valid0, out_data0, overrun0} !== {exp_valid, exp_data, exp_ovr}) begin
                n_fail++;
                $display("FAIL rnd_ovr%0d: got valid=%b data=%h ovr=%b, expected %b %h %b (%0d words)",
                         it, out_valid0, out_data0, overrun0, exp_valid, exp_data, exp_ovr, n);
            end
            align();
            a0 = acc0_q.size();
            out_ready0 = 1'b1;
            align();
            out_ready0 = 1'b0;
            @(negedge clock);
            n_tests++;
            if (acc0_q.size() - a0 !== 1 || out_valid0 !== 1'b0) begin
                n_fail++; $display("FAIL rnd_drain%0d: got %0d words valid=%b, expected 1 word valid=0", it, acc0_q.size() - a0, out_valid0);
            end else begin
                n_tests++;
                if (acc0_q[a0] !== exp_data) begin
                    n_fail++; $display("FAIL rnd_drain_data%0d: got %h, expected %h", it, acc0_q[a0], exp_data);
                end
            end
        end
    endtask

    task automatic test_mode1();
        int b1, r1, e, lat, vlat;
        align();
        out_ready1 = 1'b0;
        b1 = bits1_q.size(); r1 = vrise1_q.size();
        csn = 1'b0; #100;
        send_bits(8'h81, 8, 1'b0, e);
        #100;
        @(negedge clock);
        lat  = (pcyc1_q.size() > b1) ? pcyc1_q[b1] - e : -1;
        vlat = (pcyc1_q.size() >= b1 + 8 && vrise1_q.size() > r1) ? vrise1_q[r1] - pcyc1_q[b1 + 7] : -1;
        n_tests++;
        if (bits1_q.size() - b1 !== 8 || bit_errors(1'b1, b1, 8'h81, 8) !== 0) begin
            n_fail++; $display("FAIL m1_bits: got %0d strobes, expected 8 matching 81", bits1_q.size() - b1);
        end
        n_tests++;
        if (lat !== SS + 1) begin
            n_fail++; $display("FAIL m1_fall_latency: got %0d, expected %0d", lat, SS + 1);
        end
        n_tests++;
        if (vlat !== 2) begin
            n_fail++; $display("FAIL m1_valid_latency: got %0d, expected 2", vlat);
        end
        n_tests++;
        if ({out_valid1, out_data1, overrun1} !== {1'b1, 8'h81, 1'b0}) begin
            n_fail++; $display("FAIL m1_buffer: got valid=%b data=%h ovr=%b, expected 1 81 0", out_valid1, out_data1, overrun1);
        end
        align();
        csn = 1'b1; #200;
        out_ready1 = 1'b1;
        align();
        @(negedge clock);
        n_tests++;
        if (out_valid1 !== 1'b0) begin
            n_fail++; $display("FAIL m1_accept: got valid=%b, expected 0", out_valid1);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_reset_mid_word();
        test_random_stream();
        test_random_overrun();
        test_mode1();
        repeat (4) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_rx_controller
